// File: rtl/flash_audio_pkg.sv
// rtl/flash_audio_pkg.sv - shared types and defaults for the flash audio reader
package flash_audio_pkg;

    localparam int ADDR_W   = 23;
    localparam int SAMPLE_W = 16;
    localparam int WORD_W   = 32;

    localparam logic [ADDR_W-1:0] DEF_START_ADDR = 23'h0;
    localparam logic [ADDR_W-1:0] DEF_END_ADDR   = 23'h7FFFF;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        WAIT_DATA,
        WAIT_TICK2
    } state_e;

endpackage

// File: rtl/flash_addr_step.sv
// rtl/flash_addr_step.sv - clip word address counter with load and wrapping step
module flash_addr_step
    import flash_audio_pkg::*;
#(
    parameter logic [ADDR_W-1:0] START_ADDR = DEF_START_ADDR,
    parameter logic [ADDR_W-1:0] END_ADDR   = DEF_END_ADDR
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load_start_i,
    input  logic              load_end_i,
    input  logic              step_fwd_i,
    input  logic              step_bwd_i,
    output logic [ADDR_W-1:0] addr_o
);

    logic [ADDR_W-1:0] addr_q;
    logic [ADDR_W-1:0] addr_d;

    // Loads take priority over steps; steps wrap at the clip boundaries.
    always_comb begin
        addr_d = addr_q;
        if (load_start_i) begin
            addr_d = START_ADDR;
        end else if (load_end_i) begin
            addr_d = END_ADDR;
        end else if (step_fwd_i) begin
            addr_d = (addr_q == END_ADDR) ? START_ADDR : addr_q + ADDR_W'(1);
        end else if (step_bwd_i) begin
            addr_d = (addr_q == START_ADDR) ? END_ADDR : addr_q - ADDR_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_q <= START_ADDR;
        end else begin
            addr_q <= addr_d;
        end
    end

    assign addr_o = addr_q;

endmodule

// File: rtl/flash_audio_reader.sv
// rtl/flash_audio_reader.sv - fetches clip words from flash and plays them as 16-bit samples
module flash_audio_reader
    import flash_audio_pkg::*;
#(
    parameter logic [ADDR_W-1:0] START_ADDR = DEF_START_ADDR,
    parameter logic [ADDR_W-1:0] END_ADDR   = DEF_END_ADDR
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                bF,
    input  logic                fF,
    input  logic                rst,
    input  logic                pause,
    input  logic                sample_tick,
    output logic                flash_read,
    input  logic                flash_waitrequest,
    output logic [ADDR_W-1:0]   flash_address,
    input  logic                flash_readdatavalid,
    input  logic [WORD_W-1:0]   flash_readdata,
    output logic [ADDR_W:0]     adr,
    output logic [SAMPLE_W-1:0] audio_out,
    output logic                audio_valid
);

    state_e              state_q, state_d;
    logic                pend_q, pend_d;
    logic                wdir_q, wdir_d;
    logic [WORD_W-1:0]   word_q, word_d;
    logic [SAMPLE_W-1:0] audio_q, audio_d;
    logic                valid_q, valid_d;

    logic                load_start, load_end, step_fwd, step_bwd;
    logic [ADDR_W-1:0]   addr;
    logic                dir;
    logic                tick_ok;
    logic                unused_ff;

    // Backward wins whenever bF is set, so fF carries no extra information.
    assign dir       = bF;
    assign unused_ff = fF;
    assign tick_ok   = sample_tick & ~pause;

    always_comb begin
        state_d    = state_q;
        pend_d     = pend_q;
        wdir_d     = wdir_q;
        word_d     = word_q;
        audio_d    = audio_q;
        valid_d    = 1'b0;
        load_start = 1'b0;
        load_end   = 1'b0;
        step_fwd   = 1'b0;
        step_bwd   = 1'b0;
        case (state_q)
            IDLE: begin
                if (rst) begin
                    load_start = 1'b1;
                    pend_d     = 1'b1;
                end else if (tick_ok) begin
                    load_end = pend_q & dir;
                    pend_d   = 1'b0;
                    wdir_d   = dir;
                    state_d  = REQ;
                end
            end
            REQ: begin
                if (!flash_waitrequest) begin
                    state_d = WAIT_DATA;
                end
            end
            WAIT_DATA: begin
                // Wait for the data even under rst so no stale beat leaks into the next read.
                if (flash_readdatavalid) begin
                    if (rst) begin
                        state_d = IDLE;
                    end else begin
                        word_d  = flash_readdata;
                        audio_d = wdir_q ? flash_readdata[31:16] : flash_readdata[15:0];
                        valid_d = 1'b1;
                        state_d = WAIT_TICK2;
                    end
                end
            end
            WAIT_TICK2: begin
                if (rst) begin
                    state_d = IDLE;
                end else if (tick_ok) begin
                    audio_d  = wdir_q ? word_q[15:0] : word_q[31:16];
                    valid_d  = 1'b1;
                    step_fwd = ~dir;
                    step_bwd = dir;
                    state_d  = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            pend_q  <= 1'b0;
            wdir_q  <= 1'b0;
            word_q  <= '0;
            audio_q <= '0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            pend_q  <= pend_d;
            wdir_q  <= wdir_d;
            word_q  <= word_d;
            audio_q <= audio_d;
            valid_q <= valid_d;
        end
    end

    flash_addr_step #(
        .START_ADDR (START_ADDR),
        .END_ADDR   (END_ADDR)
    ) u_addr (
        .clk          (clk),
        .rst_n        (rst_n),
        .load_start_i (load_start),
        .load_end_i   (load_end),
        .step_fwd_i   (step_fwd),
        .step_bwd_i   (step_bwd),
        .addr_o       (addr)
    );

    assign flash_read    = (state_q == REQ);
    assign flash_address = addr;
    assign adr           = {1'b0, addr};
    assign audio_out     = audio_q;
    assign audio_valid   = valid_q;

endmodule

// File: tb/tb_flash_audio_reader.sv
// tb/tb_flash_audio_reader.sv - randomized self-checking bench for flash_audio_reader
module tb_flash_audio_reader;
    import flash_audio_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        bF = 1'b0, fF = 1'b1, rst = 1'b0, pause = 1'b0, sample_tick = 1'b0;
    logic        flash_read;
    logic        flash_waitrequest = 1'b0;
    logic [22:0] flash_address;
    logic        flash_readdatavalid = 1'b0;
    logic [31:0] flash_readdata = '0;
    logic [23:0] adr;
    logic [15:0] audio_out;
    logic        audio_valid;

    flash_audio_reader dut (
        .clk                 (clk),
        .rst_n               (rst_n),
        .bF                  (bF),
        .fF                  (fF),
        .rst                 (rst),
        .pause               (pause),
        .sample_tick         (sample_tick),
        .flash_read          (flash_read),
        .flash_waitrequest   (flash_waitrequest),
        .flash_address       (flash_address),
        .flash_readdatavalid (flash_readdatavalid),
        .flash_readdata      (flash_readdata),
        .adr                 (adr),
        .audio_out           (audio_out),
        .audio_valid         (audio_valid)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] mem(input logic [22:0] a);
        if (a == 23'd0) return 32'h1111_2222;
        if (a == 23'd1) return 32'h3333_4444;
        return {a[15:0] ^ 16'hC3A5, a[22:7] ^ a[15:0]};
    endfunction

    // Tick-level model: each accepted tick yields exactly one sample.
    logic [22:0] m_addr = '0;
    logic        m_pend = 1'b0, m_half = 1'b0, m_wdir = 1'b0;
    logic [31:0] m_word = '0;
    logic [15:0] aud_q[$];
    logic [22:0] rd_q[$];
    logic [15:0] exp_last = '0;
    logic        chk_adr = 1'b1;

    task automatic model_tick(input logic d, input logic p);
        if (p) return;
        if (!m_half) begin
            if (m_pend && d) m_addr = DEF_END_ADDR;
            m_pend = 1'b0;
            m_wdir = d;
            m_word = mem(m_addr);
            rd_q.push_back(m_addr);
            aud_q.push_back(d ? m_word[31:16] : m_word[15:0]);
            m_half = 1'b1;
        end else begin
            aud_q.push_back(m_wdir ? m_word[15:0] : m_word[31:16]);
            if (d) m_addr = (m_addr == DEF_START_ADDR) ? DEF_END_ADDR : m_addr - 23'd1;
            else   m_addr = (m_addr == DEF_END_ADDR) ? DEF_START_ADDR : m_addr + 23'd1;
            m_half = 1'b0;
        end
    endtask

    // Flash responder: random stalls, programmable read latency, handshake checks.
    int          force_stall = 0;
    int          lat_lo = 2, lat_hi = 2;
    logic        rand_stall = 1'b0;
    int          pend_cnt = 0;
    int          stall_run = 0;
    logic [22:0] pend_addr = '0;
    logic        prev_stalled = 1'b0;
    logic [22:0] prev_addr = '0;

    initial forever begin
        @(negedge clk);
        flash_readdatavalid = 1'b0;
        if (pend_cnt > 0) begin
            pend_cnt--;
            if (pend_cnt == 0) begin
                flash_readdatavalid = 1'b1;
                flash_readdata      = mem(pend_addr);
            end
        end
        if (prev_stalled && rst_n) begin
            chk("read_held", {31'd0, flash_read}, 32'd1);
            chk("addr_held", {9'd0, flash_address}, {9'd0, prev_addr});
        end
        if (flash_read) begin
            if (force_stall > 0) begin
                flash_waitrequest = 1'b1;
                force_stall--;
            end else if (rand_stall && stall_run < 2 && $urandom_range(2) == 0) begin
                flash_waitrequest = 1'b1;
            end else begin
                flash_waitrequest = 1'b0;
            end
            stall_run = flash_waitrequest ? stall_run + 1 : 0;
            if (!flash_waitrequest) begin
                n_cmp++;
                if (rd_q.size() == 0) begin
                    n_bad++;
                    $display("FAIL unexpected_read: got addr %h expected no read at %0t", flash_address, $time);
                end else begin
                    n_cmp--;
                    chk("read_addr", {9'd0, flash_address}, {9'd0, rd_q.pop_front()});
                end
                pend_cnt  = $urandom_range(lat_hi, lat_lo);
                pend_addr = flash_address;
            end
        end else begin
            flash_waitrequest = 1'($urandom_range(1));
            stall_run = 0;
        end
        prev_stalled = flash_read && flash_waitrequest;
        prev_addr    = flash_address;
    end

    // Every-cycle output checker against the model.
    initial forever begin
        @(posedge clk);
        #2;
        if (!rst_n) continue;
        if (chk_adr) chk("adr", {8'd0, adr}, {9'd0, m_addr});
        if (audio_valid) begin
            n_cmp++;
            if (aud_q.size() == 0) begin
                n_bad++;
                $display("FAIL unexpected_valid: got audio_out %h expected no pulse at %0t", audio_out, $time);
            end else begin
                n_cmp--;
                chk("audio_out", {16'd0, audio_out}, {16'd0, aud_q[0]});
                exp_last = aud_q.pop_front();
            end
        end else begin
            chk("audio_hold", {16'd0, audio_out}, {16'd0, exp_last});
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_tick(input logic d, input logic p, input logic stray);
        logic first;
        chk("latency_audio", aud_q.size(), 32'd0);
        chk("latency_read", rd_q.size(), 32'd0);
        first = !m_half;
        bF = d;
        fF = d ? 1'($urandom_range(1)) : 1'b1;
        pause = p;
        sample_tick = 1'b1;
        model_tick(d, p);
        @(negedge clk);
        sample_tick = first && !p && stray;
        @(negedge clk);
        sample_tick = 1'b0;
        cyc(12);
    endtask

    task automatic do_rst(input logic d);
        bF = d;
        fF = !d;
        rst = 1'b1;
        chk_adr = 1'b0;
        cyc(12);
        chk("rst_adr_zero", {8'd0, adr}, 32'd0);
        rst = 1'b0;
        m_addr = DEF_START_ADDR;
        m_pend = 1'b1;
        m_half = 1'b0;
        chk_adr = 1'b1;
        cyc(2);
    endtask

    logic [15:0] fwd_aud[4] = '{16'h2222, 16'h1111, 16'h4444, 16'h3333};
    logic [23:0] fwd_adr[4] = '{24'h0, 24'h1, 24'h1, 24'h2};
    logic        rdir = 1'b0;

    initial begin
        #12;
        chk("reset_adr", {8'd0, adr}, 32'd0);
        chk("reset_read", {31'd0, flash_read}, 32'd0);
        chk("reset_audio", {16'd0, audio_out}, 32'd0);
        chk("reset_valid", {31'd0, audio_valid}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        cyc(3);

        for (int i = 0; i < 4; i++) begin
            do_tick(1'b0, 1'b0, 1'b0);
            chk("fwd_audio_lit", {16'd0, audio_out}, {16'd0, fwd_aud[i]});
            chk("fwd_adr_lit", {8'd0, adr}, {8'd0, fwd_adr[i]});
        end

        do_rst(1'b1);
        do_tick(1'b1, 1'b0, 1'b0);
        chk("bwd_first_adr", {8'd0, adr}, 32'h7FFFF);
        chk("bwd_first_audio", {16'd0, audio_out}, 32'h3C5A);
        do_tick(1'b1, 1'b0, 1'b0);
        chk("bwd_second_adr", {8'd0, adr}, 32'h7FFFE);
        chk("bwd_second_audio", {16'd0, audio_out}, 32'hF000);

        do_rst(1'b1);
        do_tick(1'b1, 1'b0, 1'b0);
        do_tick(1'b0, 1'b0, 1'b0);
        chk("fwd_wrap_adr", {8'd0, adr}, 32'd0);
        chk("fwd_wrap_audio", {16'd0, audio_out}, 32'hF000);

        do_tick(1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) do_tick(1'b0, 1'b1, 1'b0);
        chk("pause_audio", {16'd0, audio_out}, 32'h2222);
        chk("pause_adr", {8'd0, adr}, 32'd0);
        do_tick(1'b0, 1'b0, 1'b0);
        chk("unpause_audio", {16'd0, audio_out}, 32'h1111);
        chk("unpause_adr", {8'd0, adr}, 32'd1);

        force_stall = 3;
        bF = 1'b0; fF = 1'b1; pause = 1'b0;
        sample_tick = 1'b1;
        rd_q.push_back(m_addr);
        @(negedge clk);
        sample_tick = 1'b0;
        rst = 1'b1;
        chk_adr = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            #1;
            chk("rst_read_held", {31'd0, flash_read}, 32'd1);
        end
        cyc(15);
        chk("midread_adr_zero", {8'd0, adr}, 32'd0);
        rst = 1'b0;
        m_addr = DEF_START_ADDR; m_pend = 1'b1; m_half = 1'b0;
        chk_adr = 1'b1;
        cyc(2);

        rand_stall = 1'b1; lat_lo = 1; lat_hi = 3;
        for (int i = 0; i < 150; i++) begin
            if ($urandom_range(19) == 0) do_rst(1'($urandom_range(1)));
            if ($urandom_range(3) == 0) rdir = ~rdir;
            do_tick(rdir, $urandom_range(3) == 0, 1'($urandom_range(1)));
        end
        if (m_half) do_tick(1'b0, 1'b0, 1'b0);

        rand_stall = 1'b0; lat_lo = 3; lat_hi = 3;
        do_tick(1'b0, 1'b0, 1'b0);
        do_tick(1'b0, 1'b0, 1'b0);
        bF = 1'b0; fF = 1'b1; pause = 1'b0;
        sample_tick = 1'b1;
        rd_q.push_back(m_addr);
        @(negedge clk);
        sample_tick = 1'b0;
        @(negedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("async_adr", {8'd0, adr}, 32'd0);
        chk("async_read", {31'd0, flash_read}, 32'd0);
        chk("async_audio", {16'd0, audio_out}, 32'd0);
        chk("async_valid", {31'd0, audio_valid}, 32'd0);
        m_addr = DEF_START_ADDR; m_pend = 1'b0; m_half = 1'b0;
        aud_q.delete();
        rd_q.delete();
        exp_last = '0;
        @(negedge clk);
        rst_n = 1'b1;
        cyc(4);
        do_tick(1'b0, 1'b0, 1'b0);
        chk("recover_audio", {16'd0, audio_out}, 32'h2222);
        do_tick(1'b0, 1'b0, 1'b0);
        chk("recover_adr", {8'd0, adr}, 32'd1);

        cyc(10);
        chk("drain_audio", aud_q.size(), 32'd0);
        chk("drain_read", rd_q.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got no end of test, expected finish before time limit");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad + 1);
        $fatal(1);
    end

endmodule

// File: doc/flash_audio_reader.md
Name: flash_audio_reader

Overview:
- Consumer end of the keyboard flag interface (bF, fF, rst, pause).
- Walks flash word addresses forward or backward and issues one flash read per word.
- Splits each 32-bit word into two 16-bit audio samples and presents them at the sample-rate strobe.
- Drives adr back to the key controller, which holds rst until adr returns to 0.

Parameters:
- START_ADDR, 23'h0, first word address of the clip.
- END_ADDR, 23'h7FFFF, last word address of the clip (inclusive).

Ports:
- clk  input  1  system clock
- rst_n  input  1  asynchronous active-low reset
- bF  input  1  play backward flag
- fF  input  1  play forward flag (bF wins if both are high)
- rst  input  1  restart request from the key controller, level
- pause  input  1  1 = hold output and stop fetching
- sample_tick  input  1  one-cycle strobe at the audio sample rate
- flash_read  output  1  read request
- flash_waitrequest  input  1  flash stall; flash_read and address must be held while high
- flash_address  output  23  word address = adr[22:0]
- flash_readdatavalid  input  1  read data strobe
- flash_readdata  input  32  read word
- adr  output  24  {1'b0, current word address}; fed back to the key controller
- audio_out  output  16  current sample, held between updates
- audio_valid  output  1  one-cycle pulse when audio_out updates

Behaviour:
- Async reset: adr=START_ADDR, flash_read=0, audio_out=0, audio_valid=0, state=IDLE, restart_pend=0, word latch=0.
- Direction dir: 1 = backward when bF=1, else forward.
- IDLE:
  - If rst=1: adr forced to START_ADDR, restart_pend=1.
  - Else if sample_tick && !pause: if restart_pend && dir, adr<=END_ADDR; clear restart_pend; go to REQ.
- REQ:
  - flash_read=1.
  - Leave to WAIT_DATA on the first cycle with flash_waitrequest=0.
- WAIT_DATA:
  - On flash_readdatavalid, latch the word.
  - If rst=1: discard the data and go to IDLE.
  - Otherwise present the first half and go to WAIT_TICK2.
  - First half: forward = [15:0], backward = [31:16], using dir sampled at entry to REQ.
  - The audio_valid pulse is in the same cycle audio_out updates (1 cycle after readdatavalid).
- WAIT_TICK2:
  - On sample_tick && !pause: present the other half with an audio_valid pulse, step adr, go to IDLE.
  - rst=1: go to IDLE without output; IDLE forces adr.
- Address step uses current dir:
  - Forward: adr==END_ADDR ? START_ADDR : adr+1.
  - Backward: adr==START_ADDR ? END_ADDR : adr-1.
- pause:
  - Sampled only in IDLE and WAIT_TICK2.
  - An in-flight read always completes.
  - audio_out holds its last value; no audio_valid while paused.
- rst mid-read:
  - flash_read is never dropped while flash_waitrequest=1.
  - Returned data is discarded.
  - adr reaches 0 within at most one cycle after reaching IDLE.
- Direction change mid-word: the current word finishes in its original half order; the new direction applies at the step.
- Latency from an accepted sample_tick in IDLE to audio_valid: 2 + waitrequest cycles + read latency.
- sample_tick arriving while in REQ or WAIT_DATA is ignored (no buffering).

Decomposition:
- Package flash_audio_pkg:
  - State enum IDLE/REQ/WAIT_DATA/WAIT_TICK2.
  - Default START_ADDR/END_ADDR.
  - Sample width 16, word width 32.
- Sub-module flash_addr_step: registered address counter with load-start, load-end, step-forward and step-backward controls and wrap logic.
- Top level holds the FSM and the sample mux.

Test Plan:
- Forward play:
  - Stimulus: fF=1, pause=0, words 0x1111_2222 at 0 and 0x3333_4444 at 1, readdatavalid 2 cycles after the read.
  - Required: audio_out sequence 0x2222, 0x1111, 0x4444, 0x3333; adr 0 → 1 → 2.
- Backward wrap:
  - Stimulus: restart with bF=1.
  - Required: first fetch at 0x7FFFF with [31:16] output first; after two ticks adr=0x7FFFE.
- Forward wrap:
  - Stimulus: preload adr=END_ADDR, forward.
  - Required: after the second half, adr=START_ADDR=0.
- Pause:
  - Stimulus: pause=1 in WAIT_TICK2, 5 ticks.
  - Required: no audio_valid, audio_out and adr unchanged; release pause → next tick outputs the second half.
- Restart mid-read:
  - Stimulus: rst=1 while flash_waitrequest=1 for 3 cycles.
  - Required: flash_read stays high until accepted; data is discarded with no audio_valid; adr=0 while rst=1.
- Async reset:
  - Stimulus: rst_n low during WAIT_DATA.
  - Required: all outputs return to reset values immediately, with no clock edge.
